// File: rtl/sdspi_target.sv
// SPI mode-3 target with a Wishbone byte port; SPI pins are oversampled in wb_clk_i.
// Small RX/TX FIFOs decouple the CPU from the wire.

module sdspi_target_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  logic [7:0] i_din,
  input  logic       i_pop,
  output logic [7:0] o_head,
  output logic       o_empty,
  output logic       o_full
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          w_pop, w_push;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_head  = r_mem[r_rp];
  // A pop frees the slot in the same cycle, so a push into a full FIFO is accepted then.
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

module sdspi_target #(
  parameter int         DEPTH = 4,
  parameter logic [7:0] FILL  = 8'hFF
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_n_i,
  input  logic       wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  input  logic       wb_we_i,
  input  logic       wb_stb_i,
  input  logic       wb_cyc_i,
  output logic       wb_ack_o,
  input  logic       sclk_i,
  input  logic       mosi_i,
  input  logic       ss_i,
  output logic       miso_o,
  output logic       miso_oe_o,
  output logic       irq_o
);
  logic [1:0] r_sclk_s, r_mosi_s, r_ss_s;
  logic       r_sclk_d, r_ss_d;
  logic [2:0] r_bitcnt;
  logic [7:0] r_tx_sh, r_rx_sh;
  logic       r_miso, r_ack, r_rx_ovr, r_tx_udr;
  logic [7:0] r_dat;

  logic       w_sclk, w_ss, w_mosi, w_sclk_rise, w_sclk_fall, w_ss_fall, w_last;
  logic       w_tx_load, w_rx_push, w_req, w_rx_pop, w_tx_push, w_wr_stat;
  logic       w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
  logic [7:0] w_rx_head, w_tx_head, w_tx_byte, w_rx_byte, w_status;

  // Idle level is 1 on every pin, so reset the synchronisers high to avoid false edges.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_sclk_s <= '1;
      r_mosi_s <= '1;
      r_ss_s   <= '1;
      r_sclk_d <= 1'b1;
      r_ss_d   <= 1'b1;
    end else begin
      r_sclk_s <= {r_sclk_s[0], sclk_i};
      r_mosi_s <= {r_mosi_s[0], mosi_i};
      r_ss_s   <= {r_ss_s[0], ss_i};
      r_sclk_d <= r_sclk_s[1];
      r_ss_d   <= r_ss_s[1];
    end
  end

  assign w_sclk      = r_sclk_s[1];
  assign w_ss        = r_ss_s[1];
  assign w_mosi      = r_mosi_s[1];
  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk & r_sclk_d;
  assign w_ss_fall   = ~w_ss & r_ss_d;
  assign w_last      = (r_bitcnt == 3'd7);
  assign w_rx_byte   = {r_rx_sh[6:0], w_mosi};
  assign w_tx_byte   = w_tx_empty ? FILL : w_tx_head;
  assign w_tx_load   = ~w_ss & (w_ss_fall | (w_sclk_rise & w_last));
  assign w_rx_push   = ~w_ss & ~w_ss_fall & w_sclk_rise & w_last;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_bitcnt <= '0;
      r_tx_sh  <= FILL;
      r_rx_sh  <= '0;
      r_miso   <= 1'b1;
    end else if (w_ss) begin
      r_bitcnt <= '0;
      r_miso   <= 1'b1;
    end else if (w_ss_fall) begin
      r_bitcnt <= '0;
      r_tx_sh  <= w_tx_byte;
    end else if (w_sclk_fall) begin
      r_miso   <= r_tx_sh[7];
      r_tx_sh  <= {r_tx_sh[6:0], 1'b0};
    end else if (w_sclk_rise) begin
      r_rx_sh  <= w_rx_byte;
      r_bitcnt <= r_bitcnt + 3'd1;
      if (w_last) r_tx_sh <= w_tx_byte;
    end
  end

  assign miso_o    = w_ss | r_miso;
  assign miso_oe_o = ~w_ss;

  // Bus side: every action happens on the edge that raises ack, so once per ack.
  assign w_req     = wb_stb_i & wb_cyc_i & ~r_ack;
  assign w_rx_pop  = w_req & ~wb_we_i & ~wb_adr_i;
  assign w_tx_push = w_req & wb_we_i & ~wb_adr_i;
  assign w_wr_stat = w_req & wb_we_i & wb_adr_i;
  assign w_status  = {3'b0, w_ss, r_tx_udr, r_rx_ovr, w_tx_full, ~w_rx_empty};

  sdspi_target_fifo #(.DEPTH(DEPTH)) u_rx (
    .clk(wb_clk_i), .rst_n(wb_rst_n_i),
    .i_push(w_rx_push), .i_din(w_rx_byte), .i_pop(w_rx_pop),
    .o_head(w_rx_head), .o_empty(w_rx_empty), .o_full(w_rx_full)
  );

  sdspi_target_fifo #(.DEPTH(DEPTH)) u_tx (
    .clk(wb_clk_i), .rst_n(wb_rst_n_i),
    .i_push(w_tx_push), .i_din(wb_dat_i), .i_pop(w_tx_load),
    .o_head(w_tx_head), .o_empty(w_tx_empty), .o_full(w_tx_full)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_ack    <= 1'b0;
      r_dat    <= 8'h00;
      r_rx_ovr <= 1'b0;
      r_tx_udr <= 1'b0;
    end else begin
      r_ack <= w_req;
      if (w_req & ~wb_we_i)
        r_dat <= wb_adr_i ? w_status : (w_rx_empty ? 8'h00 : w_rx_head);
      // Set beats a same-cycle clear so no event is lost.
      if (w_rx_push & w_rx_full & ~w_rx_pop) r_rx_ovr <= 1'b1;
      else if (w_wr_stat & wb_dat_i[2])      r_rx_ovr <= 1'b0;
      if (w_tx_load & w_tx_empty)            r_tx_udr <= 1'b1;
      else if (w_wr_stat & wb_dat_i[3])      r_tx_udr <= 1'b0;
    end
  end

  assign wb_ack_o = r_ack;
  assign wb_dat_o = r_dat;
  assign irq_o    = ~w_rx_empty | r_rx_ovr;
endmodule

// File: tb/tb_sdspi_target.sv
// Directed bench for sdspi_target: drives an SPI mode-3 master and Wishbone cycles.
`timescale 1ns/1ps
module tb_sdspi_target;
  localparam int HP = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       adr = 1'b0, we = 1'b0, stb = 1'b0, cyc = 1'b0;
  logic [7:0] dat_i = 8'h00;
  logic [7:0] dat_o;
  logic       ack;
  logic       sclk = 1'b1, mosi = 1'b1, ss = 1'b1;
  logic       miso, miso_oe, irq;

  int checks = 0;
  int errors = 0;

  sdspi_target #(.DEPTH(4), .FILL(8'hFF)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_dat_o(dat_o),
    .wb_we_i(we), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_ack_o(ack),
    .sclk_i(sclk), .mosi_i(mosi), .ss_i(ss),
    .miso_o(miso), .miso_oe_o(miso_oe), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ss = 1'b1; sclk = 1'b1; mosi = 1'b1;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(3);
  endtask

  task automatic wb_rd(input logic a, output logic [7:0] d);
    bit got = 1'b0;
    d = 8'hxx;
    adr = a; we = 1'b0; stb = 1'b1; cyc = 1'b1;
    for (int k = 0; k < 8 && !got; k++) begin
      tick(1);
      if (ack) begin d = dat_o; got = 1'b1; end
    end
    stb = 1'b0; cyc = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL wb_rd_timeout: no ack within 8 cycles, required ack");
    end
    tick(1);
  endtask

  task automatic wb_wr(input logic a, input logic [7:0] d);
    bit got = 1'b0;
    adr = a; we = 1'b1; dat_i = d; stb = 1'b1; cyc = 1'b1;
    for (int k = 0; k < 8 && !got; k++) begin
      tick(1);
      if (ack) got = 1'b1;
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL wb_wr_timeout: no ack within 8 cycles, required ack");
    end
    tick(1);
  endtask

  task automatic spi_start();
    ss = 1'b0;
    tick(HP);
  endtask

  task automatic spi_stop();
    tick(HP);
    ss = 1'b1;
    tick(HP);
  endtask

  // Master samples MISO just before its rising edge, as a mode-3 master does.
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < n; i++) begin
      sclk = 1'b0;
      mosi = tx[7-i];
      tick(HP);
      rx = {rx[6:0], miso};
      sclk = 1'b1;
      tick(HP);
    end
  endtask

  task automatic test_reset();
    logic [7:0] rx, st;
    do_reset();
    spi_start();
    spi_bits(8'hF0, 3, rx);
    checks++;
    if (miso_oe !== 1'b1) begin errors++; $display("FAIL reset_pre_oe: got %b want 1", miso_oe); end
    rst_n = 1'b0;
    tick(1);
    checks++;
    if ({ack, dat_o, miso, miso_oe, irq} !== {1'b0, 8'h00, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b dat=%h miso=%b oe=%b irq=%b want 0 00 1 0 0",
               ack, dat_o, miso, miso_oe, irq);
    end
    ss = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(4);
    wb_rd(1'b1, st);
    checks++;
    if (st !== 8'h10) begin errors++; $display("FAIL reset_status: got %h want 10", st); end
  endtask

  task automatic test_rx();
    logic [7:0] rx, d;
    do_reset();
    spi_start();
    spi_bits(8'hA5, 8, rx);
    spi_bits(8'h3C, 8, rx);
    spi_stop();
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL rx_irq_set: got %b want 1", irq); end
    wb_rd(1'b1, d);
    checks++;
    if (d !== 8'h19) begin errors++; $display("FAIL rx_status: got %h want 19", d); end
    wb_rd(1'b0, d);
    checks++;
    if (d !== 8'hA5) begin errors++; $display("FAIL rx_byte0: got %h want a5", d); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL rx_irq_mid: got %b want 1", irq); end
    wb_rd(1'b0, d);
    checks++;
    if (d !== 8'h3C) begin errors++; $display("FAIL rx_byte1: got %h want 3c", d); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL rx_irq_clear: got %b want 0", irq); end
  endtask

  task automatic test_tx();
    logic [7:0] r0, r1, r2, st;
    do_reset();
    wb_wr(1'b0, 8'h81);
    wb_wr(1'b0, 8'h7E);
    spi_start();
    spi_bits(8'h00, 8, r0);
    spi_bits(8'h00, 8, r1);
    spi_bits(8'h00, 8, r2);
    spi_stop();
    checks++;
    if ({r0, r1, r2} !== 24'h817EFF) begin
      errors++; $display("FAIL tx_miso: got %h %h %h want 81 7e ff", r0, r1, r2);
    end
    wb_rd(1'b1, st);
    checks++;
    if (st[3] !== 1'b1) begin errors++; $display("FAIL tx_udr: status %h want bit3=1", st); end
  endtask

  task automatic test_overrun();
    logic [7:0] rx, d;
    do_reset();
    spi_start();
    for (int b = 1; b <= 5; b++) spi_bits(8'(b), 8, rx);
    spi_stop();
    wb_rd(1'b1, d);
    checks++;
    if (d !== 8'h1D) begin errors++; $display("FAIL ovr_status: got %h want 1d", d); end
    for (int b = 1; b <= 4; b++) begin
      wb_rd(1'b0, d);
      checks++;
      if (d !== 8'(b)) begin errors++; $display("FAIL ovr_read%0d: got %h want %h", b, d, 8'(b)); end
    end
    wb_rd(1'b0, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL ovr_empty_read: got %h want 00", d); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL ovr_irq: got %b want 1", irq); end
    wb_wr(1'b1, 8'h04);
    wb_rd(1'b1, d);
    checks++;
    if (d !== 8'h18) begin errors++; $display("FAIL ovr_clear: got %h want 18", d); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL ovr_irq_clear: got %b want 0", irq); end
  endtask

  task automatic test_abort();
    logic [7:0] rx, d;
    do_reset();
    spi_start();
    spi_bits(8'hFF, 5, rx);
    spi_stop();
    spi_start();
    spi_bits(8'h55, 8, rx);
    spi_stop();
    wb_rd(1'b0, d);
    checks++;
    if (d !== 8'h55) begin errors++; $display("FAIL abort_byte: got %h want 55", d); end
    wb_rd(1'b1, d);
    checks++;
    if (d[0] !== 1'b0) begin errors++; $display("FAIL abort_count: status %h want bit0=0", d); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] r0, r1, r2, d;
    logic [7:0] nxt [3] = '{8'h22, 8'h33, 8'h44};
    int acks = 0;
    do_reset();
    adr = 1'b0; we = 1'b1; dat_i = 8'h11; stb = 1'b1; cyc = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      if (ack) acks++;
      if (k < 3) dat_i = nxt[k];
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    tick(1);
    checks++;
    if (acks !== 2) begin errors++; $display("FAIL bus_acks: got %0d want 2", acks); end
    wb_rd(1'b0, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL bus_empty_read: got %h want 00", d); end
    spi_start();
    spi_bits(8'h00, 8, r0);
    spi_bits(8'h00, 8, r1);
    spi_bits(8'h00, 8, r2);
    spi_stop();
    checks++;
    if ({r0, r1, r2} !== 24'h1133FF) begin
      errors++; $display("FAIL bus_pushes: got %h %h %h want 11 33 ff", r0, r1, r2);
    end
  endtask

  initial begin
    tick(3);
    rst_n = 1'b1;
    test_reset();
    test_rx();
    test_tx();
    test_overrun();
    test_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/sdspi_target.md
# sdspi_target

SPI target (slave) with a Wishbone register port, the far end of the team's `sdspi` SPI master. It lets an external master, or a second board running `sdspi`, exchange bytes with this CPU. All SPI pins are oversampled in the single Wishbone clock domain. A small RX FIFO and TX FIFO decouple the bus from the wire.

## Interface
Parameters:
- DEPTH, 4, entries per FIFO; must be a power of 2 and at least 2.
- FILL, 8'hFF, byte shifted out when the TX FIFO is empty.

Ports:
- wb_clk_i  in  1  system clock; the only clock.
- wb_rst_n_i  in  1  asynchronous, active-low reset.
- wb_adr_i  in  1  register select: 0 = DATA, 1 = STATUS.
- wb_dat_i  in  8  write data.
- wb_dat_o  out  8  read data, registered.
- wb_we_i  in  1  write enable.
- wb_stb_i, wb_cyc_i  in  1 each  bus strobe and cycle.
- wb_ack_o  out  1  single-cycle acknowledge.
- sclk_i, mosi_i, ss_i  in  1 each  SPI from the external master; asynchronous to wb_clk_i.
- miso_o  out  1  serial data to the master.
- miso_oe_o  out  1  enable for the pad driver of miso_o.
- irq_o  out  1  interrupt: rx_nonempty | rx_ovr.

## Operation
- Protocol: SPI mode 3, matching `sdspi`.
  - SCLK idles high.
  - The target drives MISO on each falling SCLK edge.
  - The target samples MOSI on each rising SCLK edge.
  - Bit order is MSB first, 8-bit frames.
  - SS is active low.
- Synchronisers: sclk_i, mosi_i and ss_i each pass through a 2-flop synchroniser. Edge detection on the synchronised SCLK and SS uses one extra flop.
- Frame start (synchronised SS falling):
  - bit counter = 0.
  - TX shifter loads the head of the TX FIFO, popping it; if the FIFO is empty it loads FILL and sets tx_udr.
- Falling SCLK with SS low: miso_o <= shifter[7]; shifter <<= 1.
- Rising SCLK with SS low: rx_sh <= {rx_sh[6:0], mosi}; bit counter increments.
  - On the 8th rising edge:
    - rx_sh goes to the RX FIFO; if the FIFO is full the byte is dropped and rx_ovr is set.
    - bit counter wraps to 0.
    - TX shifter reloads as at frame start.
- SS high:
  - miso_oe_o = 0 and miso_o = 1.
  - A partial RX byte is discarded.
  - The bit counter clears.
  - A partially sent TX byte is lost and not re-queued.
- DATA register:
  - Read pops the RX FIFO; reading while empty returns 8'h00 and pops nothing.
  - Write pushes the TX FIFO; writing while full drops the byte.
- STATUS register:
  - Read: {3'b0, ss_sync, tx_udr, rx_ovr, tx_full, rx_nonempty}.
  - Write: writing 1 to bit 2 clears rx_ovr; writing 1 to bit 3 clears tx_udr. Other bits ignore writes.
- Simultaneous events:
  - A FIFO push and pop in the same cycle both take effect, so the count is unchanged. If the FIFO is full, that push is accepted.
  - An overrun/underrun set wins over a same-cycle clear.

## Timing
- Reset values:
  - wb_ack_o = 0, wb_dat_o = 8'h00.
  - miso_o = 1, miso_oe_o = 0, irq_o = 0.
  - FIFOs empty; rx_ovr = tx_udr = 0.
  - Synchronisers = 1, which is the idle state.
- Reset asserted mid-frame aborts everything immediately. After release the block waits for a fresh SS falling edge.
- Bus handshake:
  - wb_ack_o rises the cycle after stb & cyc is sampled with wb_ack_o low, and stays high for 1 cycle.
  - A held strobe gets an ack every 2nd cycle.
  - The FIFO push/pop and the wb_dat_o update occur on the ack cycle, exactly once per ack.
- SPI latency:
  - A pin edge acts 3 wb_clk cycles after it occurs; miso_o changes 3–4 cycles after the SCLK falling edge.
  - Requirements on the master: SCLK high and low phases each ≥ 4 wb_clk cycles. The first SCLK edge must come ≥ 4 cycles after SS falls.
- RX byte visibility: the byte is visible in STATUS and irq_o 1 cycle after the synchronised 8th rising edge.

## Test plan
- Reset: hold wb_rst_n_i low mid-frame, then release → all outputs at reset values and STATUS = 8'h10 (SS idle high).
- RX: master sends 8'hA5, 8'h3C in one SS frame → two DATA reads return A5 then 3C; irq_o falls after the second read.
- TX: preload the TX FIFO with 8'h81, 8'h7E; master clocks 3 bytes → MISO carries 81, 7E, FF, and STATUS bit 3 (tx_udr) = 1.
- Overrun: DEPTH = 4, master sends 5 bytes with no reads → reads return bytes 1–4, STATUS bit 2 = 1; writing 8'h04 to STATUS clears it.
- Abort: SS rises after 5 bits, then a new frame sends 8'h55 → only 55 appears in the RX FIFO.
- Bus: hold stb/cyc with DATA writes for 4 cycles → 2 acks and exactly 2 TX pushes; a read of the empty DATA register returns 00.
